// File: rtl/ether_pkg.sv
// ether_pkg: shared Ethernet constants, receive FSM states and out_err bit indices
package ether_pkg;
    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    localparam logic [7:0] ETH_SFD = 8'hD5;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam int ERR_CRC = 0;
    localparam int ERR_PHY = 1;
    localparam int ERR_RUNT = 2;
    localparam int ERR_LONG = 3;
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} rx_state_t;
endpackage

// File: rtl/ether_gmii_rx_if.sv
// ether_gmii_rx_if: received frame byte stream; out_valid/out_data/out_sof/out_eof plus out_good/out_err status on eof
interface ether_gmii_rx_if;
    import ether_pkg::*;
    logic out_valid;
    logic [7:0] out_data;
    logic out_sof;
    logic out_eof;
    logic out_good;
    logic [3:0] out_err;
    modport master (output out_valid, out_data, out_sof, out_eof, out_good, out_err);
    modport slave (input out_valid, out_data, out_sof, out_eof, out_good, out_err);
endinterface

// File: rtl/ether_crc32.sv
// ether_crc32: combinational one-byte step of reflected CRC-32; crc_in + data -> crc_out
module ether_crc32
    import ether_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    always_comb begin
        crc_out = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ CRC_POLY : crc_out >> 1;
    end
endmodule

// File: rtl/ether_gmii_rx.sv
// ether_gmii_rx: GMII rx framer; clk_125/rst, phy_dv/phy_er/phy_data in, frame bytes + status on rx, saturating frame_cnt/err_cnt
module ether_gmii_rx
    import ether_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522,
    parameter int CNT_W = 16
) (
    input  logic             clk_125,
    input  logic             rst,
    input  logic             phy_dv,
    input  logic             phy_er,
    input  logic [7:0]       phy_data,
    ether_gmii_rx_if.master  rx,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);
    rx_state_t state;
    logic dv_q, er_q, hold_full, sof_pend, phy_err, good_end;
    logic [7:0] data_q, hold;
    logic [10:0] len;
    logic [31:0] crc, crc_next;
    logic [3:0] err_end, err_long;
    ether_crc32 u_crc (.crc_in(crc), .data(data_q), .crc_out(crc_next));
    always_comb begin
        err_end = '0;
        err_long = '0;
        err_end[ERR_CRC] = crc != CRC_RESIDUE;
        err_end[ERR_PHY] = phy_err;
        err_end[ERR_RUNT] = len < MIN_L;
        err_long[ERR_PHY] = phy_err | er_q;
        err_long[ERR_LONG] = 1'b1;
        good_end = hold_full && err_end == '0;
    end
    always_ff @(posedge clk_125) begin
        rx.out_valid <= 1'b0;
        rx.out_sof <= 1'b0;
        rx.out_eof <= 1'b0;
        rx.out_good <= 1'b0;
        rx.out_err <= '0;
        if (rst) begin
            {dv_q, er_q, data_q} <= '0;
            state <= IDLE;
            crc <= CRC_INIT;
            len <= '0;
            hold <= '0;
            hold_full <= 1'b0;
            sof_pend <= 1'b0;
            phy_err <= 1'b0;
            rx.out_data <= '0;
            frame_cnt <= '0;
            err_cnt <= '0;
        end else begin
            {dv_q, er_q, data_q} <= {phy_dv, phy_er, phy_data};
            case (state)
                IDLE: if (dv_q) state <= data_q == ETH_PREAMBLE ? PREAMBLE : DROP;
                PREAMBLE: begin
                    state <= !dv_q ? IDLE : data_q == ETH_PREAMBLE ? PREAMBLE : data_q == ETH_SFD ? PAYLOAD : DROP;
                    crc <= CRC_INIT;
                    len <= '0;
                    phy_err <= 1'b0;
                    hold_full <= 1'b0;
                    sof_pend <= 1'b1;
                end
                PAYLOAD: if (!dv_q) begin
                    state <= IDLE;
                    hold_full <= 1'b0;
                    rx.out_valid <= hold_full;
                    rx.out_data <= hold;
                    rx.out_sof <= hold_full & sof_pend;
                    rx.out_eof <= hold_full;
                    rx.out_good <= good_end;
                    rx.out_err <= hold_full ? err_end : '0;
                    frame_cnt <= frame_cnt + CNT_W'(good_end && ~&frame_cnt);
                    err_cnt <= err_cnt + CNT_W'(!good_end && ~&err_cnt);
                end else if (len == MAX_L) begin
                    state <= DROP;
                    hold_full <= 1'b0;
                    rx.out_valid <= 1'b1;
                    rx.out_data <= hold;
                    rx.out_sof <= sof_pend;
                    rx.out_eof <= 1'b1;
                    rx.out_err <= err_long;
                    err_cnt <= err_cnt + CNT_W'(~&err_cnt);
                end else begin
                    crc <= crc_next;
                    len <= len == '1 ? len : len + 1'b1;
                    hold <= data_q;
                    hold_full <= 1'b1;
                    phy_err <= phy_err | er_q;
                    rx.out_valid <= hold_full;
                    rx.out_data <= hold;
                    rx.out_sof <= hold_full & sof_pend;
                    if (hold_full) sof_pend <= 1'b0;
                end
                DROP: if (!dv_q) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ether_gmii_rx.sv
// tb_ether_gmii_rx: directed scoreboard bench for ether_gmii_rx
module tb_ether_gmii_rx;
    typedef struct {
        logic [7:0] d;
        logic sof;
        logic eof;
        logic good;
        logic [3:0] err;
        int cyc;
    } exp_t;
    logic clk_125 = 1'b0;
    logic rst = 1'b1;
    logic phy_dv = 1'b0;
    logic phy_er = 1'b0;
    logic [7:0] phy_data = 8'h00;
    logic [15:0] frame_cnt, err_cnt;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_frames = 0;
    int exp_errs = 0;
    exp_t sb[$];
    logic [7:0] body[$];
    ether_gmii_rx_if bus ();
    ether_gmii_rx dut (
        .clk_125(clk_125), .rst(rst), .phy_dv(phy_dv), .phy_er(phy_er), .phy_data(phy_data),
        .rx(bus.master), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );
    always #4 clk_125 = ~clk_125;
    always @(posedge clk_125) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ body[i][b]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        return ~c;
    endfunction
    task automatic make_frame(input int n);
        logic [31:0] f;
        body.delete();
        for (int i = 0; i < n - 4; i++) body.push_back(8'($urandom));
        f = crc32(n - 4);
        for (int i = 0; i < 4; i++) body.push_back(f[8*i +: 8]);
    endtask
    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        phy_dv = dv;
        phy_er = er;
        phy_data = d;
        @(negedge clk_125);
    endtask
    task automatic send(input int er_at, input int rst_at);
        int n, emit;
        logic bad, good;
        logic [3:0] err;
        exp_t e;
        n = body.size();
        emit = n > 1522 ? 1522 : n;
        bad = 1'b1;
        if (n >= 4) bad = crc32(n - 4) != {body[n-1], body[n-2], body[n-3], body[n-4]};
        err = n > 1522 ? {1'b1, 1'b0, er_at >= 0, 1'b0} : {1'b0, n < 64, er_at >= 0, bad};
        good = n > 0 && err == 4'b0000;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, i < 7 ? 8'h55 : 8'hD5);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                phy_dv = 1'b0;
                phy_data = 8'h00;
                exp_frames = 0;
                exp_errs = 0;
                @(negedge clk_125);
                rst = 1'b0;
                return;
            end
            if (i < emit && (rst_at < 0 || i < rst_at - 2)) begin
                e.d = body[i];
                e.sof = i == 0;
                e.eof = rst_at < 0 && i == emit - 1;
                e.good = good;
                e.err = err;
                e.cyc = cyc + 3;
                sb.push_back(e);
            end
            drive(1'b1, i == er_at, body[i]);
        end
        drive(1'b0, 1'b0, 8'h00);
        if (good) exp_frames++;
        else exp_errs++;
    endtask
    task automatic drain(input string tag);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk_125);
        repeat (3) @(negedge clk_125);
        check({tag, " drained"}, sb.size(), 0);
        check({tag, " frame_cnt"}, frame_cnt, exp_frames);
        check({tag, " err_cnt"}, err_cnt, exp_errs);
    endtask
    always @(negedge clk_125) begin
        exp_t e;
        if (bus.out_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL extra_byte: got byte %0h sof %0b eof %0b, expected no output", bus.out_data, bus.out_sof, bus.out_eof);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", bus.out_data, e.d);
                check("out_sof", bus.out_sof, e.sof);
                check("out_eof", bus.out_eof, e.eof);
                check("latency", cyc, e.cyc);
                if (e.eof) begin
                    check("out_good", bus.out_good, e.good);
                    check("out_err", bus.out_err, e.err);
                end
            end
        end
    end
    initial begin
        repeat (3) @(negedge clk_125);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_sof", bus.out_sof, 0);
        check("rst out_eof", bus.out_eof, 0);
        check("rst out_good", bus.out_good, 0);
        check("rst out_err", bus.out_err, 0);
        check("rst out_data", bus.out_data, 0);
        check("rst frame_cnt", frame_cnt, 0);
        check("rst err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(negedge clk_125);
        make_frame(64);
        send(-1, -1);
        drain("legal");
        body[10] = body[10] ^ 8'h01;
        send(-1, -1);
        drain("bad_fcs");
        body = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        send(-1, -1);
        drain("runt");
        make_frame(80);
        send(30, -1);
        drain("phy_err");
        body.delete();
        send(-1, -1);
        drain("zero_len");
        body = '{8'hA7};
        send(-1, -1);
        drain("one_byte");
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hA5);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h11);
        drive(1'b0, 1'b0, 8'h00);
        drain("bad_preamble");
        make_frame(1600);
        send(-1, -1);
        make_frame(100);
        send(-1, -1);
        drain("overlength");
        make_frame(64);
        send(-1, 20);
        check("rst_mid out_valid", bus.out_valid, 0);
        check("rst_mid out_eof", bus.out_eof, 0);
        check("rst_mid frame_cnt", frame_cnt, exp_frames);
        check("rst_mid err_cnt", err_cnt, exp_errs);
        drain("rst_mid");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ether_gmii_rx.md
Name: ether_gmii_rx

Overview:
- GMII receive framer for the Atlys 1000BASE-T path. Consumes the PHY RX pins (RX_DV, RX_ER, RXD[7:0]), which are already retimed into the 125 MHz domain.
- Strips the preamble and SFD, checks FCS and length, and delivers frame bytes as a valid/sof/eof stream with per-frame status.
- Acts as the receive-side counterpart of the sample packet TX generator. It is instanced in main next to it, feeding downstream packet logic and the debug LEDs.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS inclusive).
- MAX_LEN, 1522, maximum legal frame length in bytes (DA through FCS inclusive).
- CNT_W, 16, width of the frame statistics counters.

Ports:
- clk_125  in  1  125 MHz clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- phy_dv  in  1  GMII RX_DV.
- phy_er  in  1  GMII RX_ER.
- phy_data  in  8  GMII RXD.
- out_valid  out  1  out_data holds a frame byte this cycle.
- out_data  out  8  frame byte, DA first, FCS bytes included.
- out_sof  out  1  first byte of frame, qualified by out_valid.
- out_eof  out  1  last byte of frame, qualified by out_valid.
- out_good  out  1  frame status, valid only with out_eof.
- out_err  out  4  {too_long, runt, phy_err, crc_err}, valid only with out_eof.
- frame_cnt  out  CNT_W  count of good frames; saturates.
- err_cnt  out  CNT_W  count of bad or aborted frames; saturates.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port clk_125, reset port rst.
- Reset: all outputs are 0, counters are 0, FSM is IDLE, CRC register is 0xFFFFFFFF, hold register is empty.
- Input stage: phy_* are registered once into dv_q, er_q and data_q. The FSM acts only on the _q signals.
- FSM states: IDLE, PREAMBLE, PAYLOAD, DROP.
- IDLE:
  - dv_q=1 with data_q=0x55 goes to PREAMBLE.
  - dv_q=1 with any other byte goes to DROP; no output, no count.
- PREAMBLE:
  - 0x55 stays in PREAMBLE.
  - 0xD5 goes to PAYLOAD; clear the CRC register, length counter and sticky flags.
  - Any other byte goes to DROP.
  - dv_q=0 goes to IDLE.
- PAYLOAD, on each byte with dv_q=1:
  - Update CRC-32 (reflected, poly 0xEDB88320).
  - Increment len (11 bits, saturating).
  - Load the byte into the hold register.
  - If the hold register was already full, emit the previous byte; out_sof is set on the first emitted byte.
- PAYLOAD, error and length handling:
  - er_q=1 sets a sticky phy_err; the frame continues.
  - When len would exceed MAX_LEN, emit the held byte with out_eof and too_long=1, then go to DROP. The FCS check is not performed (crc_err=0).
- PAYLOAD, on dv_q=0 (normal end):
  - Emit the held byte with out_eof and status, then go to IDLE.
  - crc_err = CRC register ≠ 0xDEBB20E3 (residue, no final inversion).
  - runt = len < MIN_LEN.
  - out_good = no error bit set.
- DROP: wait for dv_q=0, then go to IDLE. Nothing is emitted.
- Latency: a byte sampled on the pins at edge N is on out_data after edge N+2. This holds for every byte, including the eof byte, because the dv-low sample arrives exactly one cycle after the last byte.
- Output gaps: out_valid is a single-cycle pulse per byte, with no gaps inside a frame. There is no backpressure; the consumer must accept one byte per cycle.
- Single-byte frame: out_sof=out_eof=1 on the same byte; status is runt+crc_err.
- Zero-byte frame (dv drops right after SFD): no output; err_cnt is incremented.
- Counters: on eof, increment frame_cnt if good, otherwise err_cnt. Both hold at all-ones.
- Back-to-back frames: a new preamble may start the cycle after dv_q=0 (IFG ≥ 1). It must be accepted from IDLE.
- Reset mid-frame: immediate return to reset state; no eof is emitted for the partial frame.

Decomposition:
- Package ether_pkg holds:
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3;
  - the FSM state enum;
  - the out_err bit-index constants.
- Sub-module ether_crc32: a combinational byte-wise CRC next-state function. It is shared with the TX generator for FCS insertion.

Test Plan:
- Legal frame: 7×0x55, 0xD5, 60-byte payload, correct FCS (bench model).
  - Expect 64 out_valid pulses, sof on byte 0, eof on byte 63.
  - Expect out_good=1, out_err=0, frame_cnt=1, latency 2 cycles per byte.
- Corrupted FCS: same frame with payload byte 10 XORed with 0x01 → eof with out_good=0, out_err=4'b0001, err_cnt=1.
- Short frame: ASCII "123456789" plus FCS bytes 26 39 F4 CB (13 bytes) → CRC passes, out_err=4'b0100 (runt), 13 bytes emitted.
- phy_err: pulse phy_er for 1 cycle mid-payload in a legal frame → all bytes delivered, out_err=4'b0010.
- Overlength: 1600-byte body → eof at byte 1522 with out_err=4'b1000, nothing further until dv low. A legal frame after a 1-cycle IFG is received with out_good=1.
- Malformed and reset cases:
  - Preamble 0x55,0x55,0xA5 → no output, no counter change.
  - rst at byte 20 of a frame → outputs zero next cycle, no eof, counters cleared.
